// File: rtl/spi_rx_if.sv
// Bundle of the serial inputs and parallel results of spi_rx.
// The slave modport faces the receiver; the master modport faces the SPI source and consumer.
interface spi_rx_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 5
);
    logic              spi_cs_l;
    logic              spi_sclk;
    logic              spi_data;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              frame_err;
    logic              busy;
    logic [CNT_W-1:0]  counter;

    modport slave (
        input  spi_cs_l,
        input  spi_sclk,
        input  spi_data,
        output data_out,
        output data_valid,
        output frame_err,
        output busy,
        output counter
    );

    modport master (
        output spi_cs_l,
        output spi_sclk,
        output spi_data,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy,
        input  counter
    );
endinterface

// File: rtl/spi_rx.sv
// Oversampling SPI slave receiver: synchronizes cs/sclk/data, recovers DATA_W-bit words, flags short frames.
// Optional macro SPI_RX_LSB_FIRST_EN reverses the shift direction (first received bit lands in data_out[0]).
module spi_rx #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 5
) (
    input  logic     clk,
    input  logic     rst,
    spi_rx_if.slave  bus
);

    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("spi_rx: SYNC_STAGES must be at least 2");
    end
    if ((2 ** CNT_W) <= DATA_W) begin : g_bad_cnt
        $error("spi_rx: CNT_W too narrow to hold DATA_W");
    end

    typedef enum logic [1:0] {
        S_ARM     = 2'd0,
        S_IDLE    = 2'd1,
        S_RECV    = 2'd2,
        S_WAIT_CS = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_cs_hist;
    logic                   r_sclk_hist;

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid;
    logic              r_err;
    logic              r_busy;
    logic [ARM_W-1:0]  r_arm_cnt;

    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_shift_in;
    logic [CNT_W-1:0]  w_cnt;
    logic [DATA_W-1:0] w_data_out;
    logic              w_valid;
    logic              w_err;
    logic              w_busy;
    logic [ARM_W-1:0]  w_arm_cnt;

    logic w_cs;
    logic w_sclk;
    logic w_data;
    logic w_sclk_rise;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_last_bit;
    logic w_arm_done;

    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_data = r_data_sync[SYNC_STAGES-1];

    assign w_sclk_rise = w_sclk & ~r_sclk_hist;
    assign w_cs_rise   = w_cs & ~r_cs_hist;
    assign w_cs_fall   = ~w_cs & r_cs_hist;
    assign w_last_bit  = w_sclk_rise && (r_cnt == CNT_W'(DATA_W - 1));

    // Synchronizers hold reset idle values for SYNC_STAGES cycles; ARM only trusts cs once real pin samples arrive.
    assign w_arm_done = (r_arm_cnt == ARM_W'(SYNC_STAGES));

`ifdef SPI_RX_LSB_FIRST_EN
    assign w_shift_in = {w_data, r_shift[DATA_W-1:1]};
`else
    assign w_shift_in = {r_shift[DATA_W-2:0], w_data};
`endif

    // Input synchronizers and edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_data_sync <= '0;
            r_cs_hist   <= 1'b1;
            r_sclk_hist <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs_l};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.spi_data};
            r_cs_hist   <= w_cs;
            r_sclk_hist <= w_sclk;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ARM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ARM: begin
                if (w_arm_done && w_cs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_bit) begin
                    w_state_nxt = S_WAIT_CS;
                end
            end
            S_WAIT_CS: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_ARM;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        w_shift    = r_shift;
        w_cnt      = r_cnt;
        w_data_out = r_data_out;
        w_valid    = 1'b0;
        w_err      = 1'b0;
        w_arm_cnt  = r_arm_cnt;
        w_busy     = (w_state_nxt == S_RECV) || (w_state_nxt == S_WAIT_CS);
        case (r_state)
            S_ARM: begin
                if (!w_arm_done) begin
                    w_arm_cnt = r_arm_cnt + ARM_W'(1);
                end
            end
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_shift = '0;
                    w_cnt   = '0;
                end
            end
            S_RECV: begin
                if (w_sclk_rise) begin
                    w_shift = w_shift_in;
                    w_cnt   = r_cnt + CNT_W'(1);
                end
                if (w_last_bit) begin
                    w_data_out = w_shift_in;
                    w_valid    = 1'b1;
                end else if (w_cs_rise) begin
                    w_err = 1'b1;
                end
            end
            S_WAIT_CS: begin
                if (w_cs_rise) begin
                    w_cnt = '0;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_arm_cnt  <= '0;
        end else begin
            r_shift    <= w_shift;
            r_cnt      <= w_cnt;
            r_data_out <= w_data_out;
            r_valid    <= w_valid;
            r_err      <= w_err;
            r_busy     <= w_busy;
            r_arm_cnt  <= w_arm_cnt;
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_valid;
    assign bus.frame_err  = r_err;
    assign bus.busy       = r_busy;
    assign bus.counter    = r_cnt;

endmodule

// File: doc/spi_rx.md
Name: spi_rx

Overview:
- SPI receiver (slave end) for the 16-bit write-only link driven by the `spi` master: consumes `spi_cs_l`/`spi_sclk`/`spi_data` and recovers each 16-bit word.
- SPI inputs are oversampled by the system clock `clk`: synchronized, edge-detected and shifted in MSB-first.
- Each completed word appears on a parallel output with a one-cycle valid strobe.
- Short frames (CS released early) are discarded and flagged.

Parameters:
- DATA_W, 16, bits per frame.
- SYNC_STAGES, 2, flip-flop synchronizer depth on `spi_cs_l`, `spi_sclk`, `spi_data` (minimum 2).
- CNT_W, 5, bit-counter width; must hold DATA_W (clog2(DATA_W+1)).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- spi_cs_l  input  1  chip select from master, active-low, asynchronous to clk.
- spi_sclk  input  1  serial clock from master, idle low, asynchronous to clk.
- spi_data  input  1  serial data from master; sampled on sclk rising edge.
- data_out  output  DATA_W  last complete received word.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- frame_err  output  1  one-cycle pulse when CS deasserts before DATA_W bits.
- busy  output  1  high while in RECV or WAIT_CS.
- counter  output  CNT_W  bits received in current frame.

Behaviour:
- Reset (rst=1 at a clk edge):
  - data_out=0, data_valid=0, frame_err=0, busy=0, counter=0.
  - Shift register 0, synchronizers and edge history loaded with idle values (cs=1, sclk=0, data=0).
  - State goes to ARM. Reset overrides everything, including mid-frame.
- Input conditioning:
  - Each SPI input passes through SYNC_STAGES flops, plus one history flop on sclk and cs.
  - sclk_rise = synced sclk 1 & history 0. cs_fall / cs_rise defined likewise on synced cs.
  - Synced data is sampled at the same clk edge as sclk_rise.
  - Master must hold sclk high and low each ≥ 2 clk periods; faster sclk is unsupported.
- States:
  - ARM: wait for synced cs=1, then go to IDLE. This guarantees a frame already in progress at reset is never captured.
  - IDLE: on cs_fall, clear shift register and counter, go to RECV.
  - RECV: on each sclk_rise, shift register <= {shift[DATA_W-2:0], data} and counter++.
    - The edge that makes counter==DATA_W loads data_out with the completed word, pulses data_valid, and goes to WAIT_CS.
    - A cs_rise with counter<DATA_W pulses frame_err, goes to IDLE, and leaves data_out unchanged.
  - WAIT_CS: further sclk_rise edges are ignored (counter holds at DATA_W). On cs_rise go to IDLE and clear counter.
- Simultaneous events:
  - cs_rise together with the DATA_W-th sclk_rise completes the frame: data_valid=1, frame_err=0, and the state goes straight to IDLE.
  - cs_fall is only acted on in IDLE.
- Latency: data_valid asserts at the clk edge SYNC_STAGES+1 edges after the first clk edge that sees spi_sclk high at the pin (3 edges for default).
- Pulse widths: data_valid and frame_err are never high for more than one cycle each, and are never high together.
- busy=1 exactly in RECV and WAIT_CS.

Optional Feature:
- Macro: SPI_RX_LSB_FIRST_EN.
- Defined: shift direction reversed, shift <= {data, shift[DATA_W-1:1]}, so the first received bit lands in data_out[0].
- Undefined (default): MSB-first as above, matching the `spi` master.
- State machine, counter and all timing are identical either way.

Test Plan:
- Reset, then behavioural master sends 16'hA569 (sclk half-period 4 clk) -> single data_valid pulse, data_out=16'hA569, counter reaches 16, frame_err stays 0.
- Back-to-back frames 16'h2563 then 16'h9B63, 2-clk CS-high gap -> two data_valid pulses with data_out 16'h2563 then 16'h9B63; busy drops between frames.
- After 16'h6A61, master sends only 9 bits of 16'hA265 then raises CS -> one frame_err pulse, no data_valid, data_out stays 16'h6A61.
- 16'h7564 followed by a 17th sclk edge before CS rises -> data_out=16'h7564, counter holds 16, no second pulse.
- rst pulsed after 8 bits of a frame with CS held low, then master finishes -> no data_valid for that frame (ARM waits for CS high); next full frame 16'hA569 received correctly.
- SPI_RX_LSB_FIRST_EN defined, master shifts 16'hA569 LSB-first -> data_out=16'hA569.
